// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial pattern detector with KMP-style fallback and a
// saturating match counter. The transition table is built at elaboration.
module mealy_seq_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           In,
    input  logic                           In_Valid,
    input  logic                           Clear,
    output logic                           Match,
    output logic [CNT_W-1:0]               Match_Count,
    output logic                           Saturated,
    output logic [$clog2(PATTERN_LEN)-1:0] State
);

    localparam int SW    = $clog2(PATTERN_LEN);
    localparam int TAB_W = 2 * PATTERN_LEN * SW;

    // Bit of the pattern received at position pos (0 = first bit = MSB).
    function automatic logic pat_bit(input int unsigned pos);
        logic [PATTERN_LEN-1:0] t;
        t = PATTERN >> (PATTERN_LEN - 1 - pos);
        return t[0];
    endfunction

    // Entry {k, b}: longest pattern prefix (shorter than the pattern) that is a
    // suffix of the k matched bits followed by b; a full match with no overlap
    // restarts from empty.
    function automatic logic [TAB_W-1:0] build_table();
        logic [TAB_W-1:0] tab;
        int unsigned      best;
        int unsigned      pos;
        logic             ok;
        logic             sb;
        logic             b;
        tab = '0;
        for (int unsigned k = 0; k < PATTERN_LEN; k++) begin
            for (int unsigned bi = 0; bi < 2; bi++) begin
                b    = (bi == 1);
                best = 0;
                if (OVERLAP || (k != PATTERN_LEN - 1) || (b != pat_bit(k))) begin
                    for (int unsigned len = 1; (len <= k + 1) && (len < PATTERN_LEN); len++) begin
                        ok = 1'b1;
                        for (int unsigned m = 0; m < len; m++) begin
                            pos = k + 1 - len + m;
                            sb  = (pos == k) ? b : pat_bit(pos);
                            if (sb != pat_bit(m)) ok = 1'b0;
                        end
                        if (ok) best = len;
                    end
                end
                tab = tab | (TAB_W'(best) << ((2 * k + bi) * SW));
            end
        end
        return tab;
    endfunction

    localparam logic [TAB_W-1:0] NEXT_TAB = build_table();
    localparam logic [SW-1:0]    LAST     = SW'(PATTERN_LEN - 1);

    logic [SW-1:0] next_state;

    always_comb begin
        next_state = SW'(NEXT_TAB >> (int'({State, In}) * SW));
        Match      = In_Valid & ~Clear & ~Reset & (State == LAST) & (In == PATTERN[0]);
        Saturated  = &Match_Count;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            State       <= '0;
            Match_Count <= '0;
        end else if (Clear) begin
            State       <= '0;
            Match_Count <= '0;
        end else if (In_Valid) begin
            State <= next_state;
            if (Match && !Saturated) Match_Count <= Match_Count + 1'b1;
        end
    end

endmodule
